pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage pipeline (fetch, decode, execute, memory, write-back).
- Drives PC write and per-stage pipeline-register write/flush controls for three cases: load-use stalls, branches taken in MEM, and data-memory wait states.
- Also runs an orderly halt/drain sequence and keeps saturating stall/flush statistics.
- Sits beside the datapath; inputs come from the ID, EX and MEM stage fields; outputs gate the IF_ID, ID_EX, EX_MEM and MEM_WB registers and the PC register.

Parameters:
DRAIN_CYCLES, 4, cycles of bubble injection after halt before entering HALTED (1..15)
TIMEOUT, 16, consecutive dmem_busy cycles before timeout_err is set (2..255)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
id_rs  in  5  rs field of instruction in IF_ID
id_rt  in  5  rt field of instruction in IF_ID
id_uses_rt  in  1  decoded instruction reads rt as a source
ex_mem_read  in  1  MemRead bit of ID_EX M field
ex_rt  in  5  destination rt of instruction in ID_EX
mem_pcsrc  in  1  branch taken, resolved in MEM (zero & Branch)
dmem_busy  in  1  data memory not ready this cycle
halt_req  in  1  request halt (level, sampled in RUN)
resume  in  1  leave HALTED (pulse)
pc_write  out  1  PC loads next value
if_id_write  out  1  IF_ID register enable
id_ex_write  out  1  ID_EX register enable
ex_mem_write  out  1  EX_MEM register enable
if_id_flush  out  1  IF_ID loads zeros at next edge (overrides write)
id_ex_flush  out  1  ID_EX loads zeros
ex_mem_flush  out  1  EX_MEM loads zeros
mem_wb_flush  out  1  MEM_WB loads zeros
halted  out  1  controller is in HALTED
timeout_err  out  1  sticky memory-wait timeout
stall_cycles  out  CNT_W  saturating count of stalled/frozen cycles
flush_events  out  CNT_W  saturating count of taken-branch flushes

Behaviour:
- Clocking and reset: one clock clk; synchronous active-high reset rst.
- While rst=1:
  - pc_write, all *_write = 0; all *_flush = 1.
  - halted = 0, timeout_err = 0, counters = 0.
  - Next state RUN, drain_cnt = 0, wait_cnt = 0.
- States: RUN, WAIT, DRAIN, HALTED (encoding in package).
- Control outputs are combinational from state and inputs; state, counters and timeout_err are registered. Defaults: all writes 1, all flushes 0.
- Priority within a cycle, highest first:
  1. HALTED: all writes 0, flushes 0.
  2. dmem_busy (freeze): pc_write = if_id_write = id_ex_write = ex_mem_write = 0; mem_wb_flush = 1 (no duplicate write-back). A mem_pcsrc in the same cycle is ignored; it is re-evaluated when busy drops, because the branch stays in EX_MEM.
  3. mem_pcsrc: if_id_flush = id_ex_flush = ex_mem_flush = 1; pc_write = 1 (branch target) except in DRAIN, where pc_write = 0.
  4. load-use: ex_mem_read & ex_rt != 0 & (ex_rt == id_rs | (id_uses_rt & ex_rt == id_rt)). Then pc_write = 0, if_id_write = 0, id_ex_flush = 1. Exactly one bubble results, because the bubble clears ex_mem_read.
  5. In DRAIN only: pc_write = 0, if_id_flush = 1 (bubbles enter decode).
- Transitions:
  - RUN → WAIT when dmem_busy.
  - RUN → DRAIN when halt_req & !dmem_busy; drain_cnt = DRAIN_CYCLES - 1.
  - WAIT → previous non-wait state (RUN or DRAIN, held in a return register) when !dmem_busy.
  - DRAIN:
    - drain_cnt decrements on cycles without freeze or load-use.
    - If dmem_busy, → WAIT.
    - When drain_cnt == 0 and the cycle is not stalled, → HALTED.
  - HALTED → RUN on resume.
  - halt_req is ignored outside RUN.
- wait_cnt:
  - Increments each consecutive dmem_busy cycle in any non-HALTED state; clears when busy is low.
  - When wait_cnt reaches TIMEOUT - 1 with busy still high, timeout_err is set at the next edge and stays until rst. The freeze continues regardless.
- stall_cycles: +1 per cycle with freeze or load-use stall; saturates at all-ones.
- flush_events: +1 per cycle where rule 3 applies; saturates at all-ones.
- Reset mid-WAIT or mid-DRAIN: rst wins; state returns to RUN next cycle with no residual count.

Decomposition:
- Shared package (pipeline_ctrl_pkg) holds:
  - the state typedef/localparams (RUN, WAIT, DRAIN, HALTED);
  - widths of register fields (5-bit register index, 32-bit word).
- One sub-module, sat_counter (width parameter, inc, clr, value), instantiated twice for the statistics.
- Hazard detection stays inline.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 for one cycle → pc_write=0, if_id_write=0, id_ex_flush=1 that cycle only; stall_cycles=1.
- Load to $0: ex_mem_read=1, ex_rt=0, id_rs=0 → no stall; all writes 1.
- Branch with hazard: mem_pcsrc=1 and a load-use condition in the same cycle → flushes on IF_ID/ID_EX/EX_MEM, pc_write=1; flush_events=1, stall_cycles=0.
- Busy then branch: dmem_busy high 3 cycles with mem_pcsrc=1 → writes 0 and mem_wb_flush=1 for 3 cycles, no flush; cycle 4 → branch flush; stall_cycles=3, flush_events=1.
- Timeout: dmem_busy held 16 cycles → timeout_err rises after the 16th cycle and stays 1 after busy drops, until rst.
- Halt/drain: halt_req in RUN, no stalls → 4 DRAIN cycles with pc_write=0 and if_id_flush=1, then halted=1. resume → RUN. A rst during DRAIN returns to RUN with counters 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: controller
// state encoding and datapath field widths.
package pipeline_ctrl_pkg;

    localparam int REG_IDX_W = 5;
    localparam int WORD_W    = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN    = 2'd0;
    localparam state_t ST_WAIT   = 2'd1;
    localparam state_t ST_DRAIN  = 2'd2;
    localparam state_t ST_HALTED = 2'd3;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for pipeline statistics. Synchronous reset and
// clear; holds at all-ones once reached.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] value_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, otherwise increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign value_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencing controller for the 5-stage pipeline. Generates PC and
// pipeline-register write/flush controls for load-use stalls, MEM-resolved
// taken branches and data-memory wait states, runs a halt/drain sequence,
// and keeps saturating stall/flush statistics.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int TIMEOUT      = 16,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_uses_rt,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rt,
    input  logic                 mem_pcsrc,
    input  logic                 dmem_busy,
    input  logic                 halt_req,
    input  logic                 resume,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 id_ex_write,
    output logic                 ex_mem_write,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 ex_mem_flush,
    output logic                 mem_wb_flush,
    output logic                 halted,
    output logic                 timeout_err,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_events
);

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

    state_t     state_q,     state_d;
    state_t     ret_q,       ret_d;
    logic [3:0] drain_cnt_q, drain_cnt_d;
    logic [7:0] wait_cnt_q,  wait_cnt_d;
    logic       timeout_q,   timeout_d;

    logic load_use_s;
    logic draining_s;
    logic stall_s;
    logic flush_evt_s;
    logic pc_write_s, if_id_write_s, id_ex_write_s, ex_mem_write_s;
    logic if_id_flush_s, id_ex_flush_s, ex_mem_flush_s, mem_wb_flush_s;
    logic halted_s;

    // Load-use hazard: a load in EX targets a non-zero register read in ID.
    assign load_use_s = ex_mem_read && (ex_rt != 5'd0) &&
                        ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // The cycle a wait returns to DRAIN still injects bubbles, otherwise one
    // extra instruction would be fetched mid-drain.
    assign draining_s = (state_q == ST_DRAIN) ||
                        ((state_q == ST_WAIT) && (ret_q == ST_DRAIN));

    // Pipeline control outputs, resolved in priority order.
    always_comb begin
        pc_write_s     = 1'b1;
        if_id_write_s  = 1'b1;
        id_ex_write_s  = 1'b1;
        ex_mem_write_s = 1'b1;
        if_id_flush_s  = 1'b0;
        id_ex_flush_s  = 1'b0;
        ex_mem_flush_s = 1'b0;
        mem_wb_flush_s = 1'b0;
        halted_s       = 1'b0;
        stall_s        = 1'b0;
        flush_evt_s    = 1'b0;
        if (rst) begin
            pc_write_s     = 1'b0;
            if_id_write_s  = 1'b0;
            id_ex_write_s  = 1'b0;
            ex_mem_write_s = 1'b0;
            if_id_flush_s  = 1'b1;
            id_ex_flush_s  = 1'b1;
            ex_mem_flush_s = 1'b1;
            mem_wb_flush_s = 1'b1;
        end else if (state_q == ST_HALTED) begin
            pc_write_s     = 1'b0;
            if_id_write_s  = 1'b0;
            id_ex_write_s  = 1'b0;
            ex_mem_write_s = 1'b0;
            halted_s       = 1'b1;
        end else if (dmem_busy) begin
            // Freeze; a pending branch stays in EX_MEM and is seen later.
            pc_write_s     = 1'b0;
            if_id_write_s  = 1'b0;
            id_ex_write_s  = 1'b0;
            ex_mem_write_s = 1'b0;
            mem_wb_flush_s = 1'b1;
            stall_s        = 1'b1;
        end else if (mem_pcsrc) begin
            if_id_flush_s  = 1'b1;
            id_ex_flush_s  = 1'b1;
            ex_mem_flush_s = 1'b1;
            pc_write_s     = !draining_s;
            flush_evt_s    = 1'b1;
        end else if (load_use_s) begin
            pc_write_s     = 1'b0;
            if_id_write_s  = 1'b0;
            id_ex_flush_s  = 1'b1;
            stall_s        = 1'b1;
        end else if (draining_s) begin
            pc_write_s     = 1'b0;
            if_id_flush_s  = 1'b1;
        end else begin
            pc_write_s     = 1'b1;
        end
    end

    // Sequencing state, return state and drain countdown.
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (dmem_busy) begin
                    state_d = ST_WAIT;
                    ret_d   = ST_RUN;
                end else if (halt_req) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_INIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_WAIT: begin
                if (!dmem_busy) begin
                    state_d = ret_q;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (dmem_busy) begin
                    state_d = ST_WAIT;
                    ret_d   = ST_DRAIN;
                end else if (load_use_s && !mem_pcsrc) begin
                    state_d = ST_DRAIN;
                end else if (drain_cnt_q == 4'd0) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_cnt_d = drain_cnt_q - 4'd1;
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Consecutive-busy counter and sticky timeout flag.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        if (dmem_busy && (state_q != ST_HALTED)) begin
            if (wait_cnt_q == WAIT_LAST) begin
                timeout_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end else begin
            wait_cnt_d = 8'd0;
        end
    end

    // Controller registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            ret_q       <= ST_RUN;
            drain_cnt_q <= 4'd0;
            wait_cnt_q  <= 8'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            drain_cnt_q <= drain_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (1'b0),
        .inc_i   (stall_s),
        .value_o (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (1'b0),
        .inc_i   (flush_evt_s),
        .value_o (flush_events)
    );

    assign pc_write     = pc_write_s;
    assign if_id_write  = if_id_write_s;
    assign id_ex_write  = id_ex_write_s;
    assign ex_mem_write = ex_mem_write_s;
    assign if_id_flush  = if_id_flush_s;
    assign id_ex_flush  = id_ex_flush_s;
    assign ex_mem_flush = ex_mem_flush_s;
    assign mem_wb_flush = mem_wb_flush_s;
    assign halted       = halted_s;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: table-driven single-cycle
// hazard vectors plus hand-written multi-cycle sequences; expected control
// words go through a scoreboard queue.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_mem_read, mem_pcsrc, dmem_busy, halt_req, resume;
    logic        pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic        halted, timeout_err;
    logic [15:0] stall_cycles, flush_events;

    int checks = 0;
    int errors = 0;

    // Control word layout: {pc, ifid_w, idex_w, exmem_w, ifid_f, idex_f, exmem_f, memwb_f, halted}
    localparam logic [8:0] C_RUN    = 9'b1111_0000_0;
    localparam logic [8:0] C_LU     = 9'b0011_0100_0;
    localparam logic [8:0] C_BR     = 9'b1111_1110_0;
    localparam logic [8:0] C_FRZ    = 9'b0000_0001_0;
    localparam logic [8:0] C_DRAIN  = 9'b0111_1000_0;
    localparam logic [8:0] C_HALT   = 9'b0000_0000_1;
    localparam logic [8:0] C_RST    = 9'b0000_1111_0;

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       mread;
        logic [4:0] xrt;
        logic       pcsrc;
        logic [8:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [8:0] exp;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[8];

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(4), .TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_pcsrc(mem_pcsrc),
        .dmem_busy(dmem_busy), .halt_req(halt_req), .resume(resume),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .halted(halted),
        .timeout_err(timeout_err), .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive nothing new; push expectation, compare at negedge, advance past next posedge.
    task automatic step(input string nm, input logic [8:0] exp);
        sb_t e;
        logic [8:0] act;
        sb_q.push_back('{nm, exp});
        @(negedge clk);
        act = {pc_write, if_id_write, id_ex_write, ex_mem_write,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, halted};
        e = sb_q.pop_front();
        checks++;
        if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: ctl got %b expected %b", e.name, act, e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rt = 1'b0; ex_mem_read = 1'b0; mem_pcsrc = 1'b0;
        dmem_busy = 1'b0; halt_req = 1'b0; resume = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step("reset_ctl", C_RST);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"idle",          5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, C_RUN};
        vecs[1] = '{"load_use_rs",   5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, C_LU};
        vecs[2] = '{"load_r0",       5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, C_RUN};
        vecs[3] = '{"load_use_rt",   5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, C_LU};
        vecs[4] = '{"rt_not_used",   5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, C_RUN};
        vecs[5] = '{"no_mem_read",   5'd9, 5'd9, 1'b1, 1'b0, 5'd9, 1'b0, C_RUN};
        vecs[6] = '{"branch",        5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, C_BR};
        vecs[7] = '{"branch_hazard", 5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1, C_BR};

        idle_inputs();
        rst = 1'b1;
        #1;
        do_reset();
        check_val("reset_stall", stall_cycles, 16'd0);
        check_val("reset_flush", flush_events, 16'd0);
        check_val("reset_timeout", {15'd0, timeout_err}, 16'd0);
        check_val("reset_halted", {15'd0, halted}, 16'd0);

        // Single-cycle hazard table.
        for (int i = 0; i < 8; i++) begin
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_uses_rt = vecs[i].uses_rt;
            ex_mem_read = vecs[i].mread; ex_rt = vecs[i].xrt; mem_pcsrc = vecs[i].pcsrc;
            step(vecs[i].name, vecs[i].exp);
        end
        idle_inputs();
        check_val("table_stall", stall_cycles, 16'd2);
        check_val("table_flush", flush_events, 16'd2);

        // Busy for three cycles with a pending branch, then the branch flushes.
        do_reset();
        mem_pcsrc = 1'b1; dmem_busy = 1'b1;
        for (int i = 0; i < 3; i++) step("busy_branch_frz", C_FRZ);
        dmem_busy = 1'b0;
        step("busy_branch_flush", C_BR);
        mem_pcsrc = 1'b0;
        step("after_busy_run", C_RUN);
        check_val("busy_stall", stall_cycles, 16'd3);
        check_val("busy_flush", flush_events, 16'd1);

        // Memory-wait timeout, sticky until reset.
        do_reset();
        dmem_busy = 1'b1;
        for (int i = 0; i < 15; i++) step("timeout_frz", C_FRZ);
        check_val("timeout_pre", {15'd0, timeout_err}, 16'd0);
        step("timeout_frz16", C_FRZ);
        check_val("timeout_set", {15'd0, timeout_err}, 16'd1);
        dmem_busy = 1'b0;
        step("timeout_release", C_RUN);
        step("timeout_run", C_RUN);
        check_val("timeout_sticky", {15'd0, timeout_err}, 16'd1);
        check_val("timeout_stall", stall_cycles, 16'd16);
        do_reset();
        check_val("timeout_cleared", {15'd0, timeout_err}, 16'd0);

        // Halt / drain / resume.
        halt_req = 1'b1;
        step("halt_req_run", C_RUN);
        halt_req = 1'b0;
        for (int i = 0; i < 4; i++) step("drain", C_DRAIN);
        step("halted", C_HALT);
        halt_req = 1'b1;
        step("halted_ignore_halt", C_HALT);
        halt_req = 1'b0;
        resume = 1'b1;
        step("halted_resume", C_HALT);
        resume = 1'b0;
        step("resumed_run", C_RUN);

        // Reset in the middle of a drain.
        ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
        step("pre_drain_lu", C_LU);
        idle_inputs();
        check_val("pre_drain_stall", stall_cycles, 16'd1);
        halt_req = 1'b1;
        step("halt_req2", C_RUN);
        halt_req = 1'b0;
        step("drain2_a", C_DRAIN);
        step("drain2_b", C_DRAIN);
        do_reset();
        step("post_rst_run", C_RUN);
        step("post_rst_run2", C_RUN);
        check_val("post_rst_stall", stall_cycles, 16'd0);
        check_val("post_rst_halted", {15'd0, halted}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
